// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: 4x4 matrix keypad scanner with debounce, key decode and code-lock checking.
// Latency: 2-cycle column synchroniser, DEBOUNCE_CYCLES on press and on release, 1-cycle check.
// Backpressure: none; key_valid is a 1-cycle strobe and the keypad is ignored while locked out.
// Ports: clk, reset (async, active-high), cols (active-low, async), prog_en (reprogram level),
//        rows (one bit low while scanning), key_valid/key_code (accepted key), digit_cnt,
//        crct_pwd/incrct_pwd/pwd_updated (result levels), locked (lockout active).
module keypad_lock_ctrl #(
    parameter int          PWD_LEN         = 4,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          MAX_TRIES       = 3,
    parameter int          LOCKOUT_CYCLES  = 48000000,
    parameter logic [31:0] DEFAULT_PWD     = 32'h0000_1234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    input  logic       prog_en,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_cnt,
    output logic       crct_pwd,
    output logic       incrct_pwd,
    output logic       pwd_updated,
    output logic       locked
);
    localparam int PW  = 4 * PWD_LEN;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LKW = $clog2(LOCKOUT_CYCLES) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LKW-1:0] LK_LAST = LKW'(LOCKOUT_CYCLES - 1);

    localparam logic [2:0] S_SCAN    = 3'd0;
    localparam logic [2:0] S_DEB_P   = 3'd1;
    localparam logic [2:0] S_ACCEPT  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DEB_R   = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_LOCKOUT = 3'd6;

    logic [2:0]     state, state_nxt;
    logic [3:0]     cols_s1, cols_s2, row_d1, row_d;
    logic           press, aligned;
    logic [1:0]     col_sel;
    logic [15:0]    row_tbl;
    logic [3:0]     dec_code, pend_code;
    logic [DBW-1:0] db_cnt;
    logic [LKW-1:0] lk_cnt;
    logic [PW-1:0]  entry, password;
    logic [3:0]     fail_cnt, fail_inc;
    logic           entry_full, match;

    // Row drive is delayed by the same two flops as the columns so row_d
    // always names the row that produced the columns in cols_s2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cols_s1 <= 4'hF;
            cols_s2 <= 4'hF;
            row_d1  <= 4'b1110;
            row_d   <= 4'b1110;
        end else begin
            cols_s1 <= cols;
            cols_s2 <= cols_s1;
            row_d1  <= rows;
            row_d   <= row_d1;
        end
    end

    assign press      = (cols_s2 != 4'hF);
    // After freezing the rows, the pipeline still carries two samples taken
    // under other rows; debounce only judges samples taken under the frozen row.
    assign aligned    = (row_d == rows);
    assign entry_full = (digit_cnt == 4'(PWD_LEN));
    assign match      = (entry == password);
    assign fail_inc   = fail_cnt + 4'd1;

    // Each row's keys packed as nibbles, column 3 in the top nibble.
    always_comb begin
        if (!cols_s2[3])      col_sel = 2'd3;
        else if (!cols_s2[2]) col_sel = 2'd2;
        else if (!cols_s2[1]) col_sel = 2'd1;
        else                  col_sel = 2'd0;
        case (row_d)
            4'b0111: row_tbl = 16'h123A;
            4'b1011: row_tbl = 16'h456B;
            4'b1101: row_tbl = 16'h789C;
            4'b1110: row_tbl = 16'hE0FD;
            default: row_tbl = 16'h0000;
        endcase
        dec_code = row_tbl[{col_sel, 2'b00} +: 4];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SCAN:    if (press && row_d != 4'hF) state_nxt = S_DEB_P;
            S_DEB_P:   if (aligned) begin
                           if (!press)                 state_nxt = S_SCAN;
                           else if (db_cnt >= DB_LAST) state_nxt = S_ACCEPT;
                       end
            S_ACCEPT:  state_nxt = S_HOLD;
            S_HOLD:    if (!press) state_nxt = S_DEB_R;
            S_DEB_R:   if (!press && db_cnt >= DB_LAST)
                           state_nxt = entry_full ? S_CHECK : S_SCAN;
            S_CHECK:   state_nxt = (!prog_en && !match && fail_inc == 4'(MAX_TRIES))
                                   ? S_LOCKOUT : S_SCAN;
            S_LOCKOUT: if (lk_cnt >= LK_LAST) state_nxt = S_SCAN;
            default:   state_nxt = S_SCAN;
        endcase
    end

    // Saturating counters, cleared on every state change. A press during
    // release debounce restarts the release count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            lk_cnt <= '0;
        end else if (state_nxt != state) begin
            db_cnt <= '0;
            lk_cnt <= '0;
        end else begin
            if ((state == S_DEB_P && aligned && press) || (state == S_DEB_R && !press)) begin
                if (!(&db_cnt)) db_cnt <= db_cnt + 1'b1;
            end else if (state == S_DEB_R) begin
                db_cnt <= '0;
            end
            if (state == S_LOCKOUT && !(&lk_cnt)) lk_cnt <= lk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_SCAN;
            rows        <= 4'b1110;
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            pend_code   <= 4'h0;
            digit_cnt   <= 4'd0;
            entry       <= '0;
            password    <= DEFAULT_PWD[PW-1:0];
            fail_cnt    <= 4'd0;
            crct_pwd    <= 1'b0;
            incrct_pwd  <= 1'b0;
            pwd_updated <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state     <= state_nxt;
            // key_code is loaded on entry to ACCEPT so it is valid with the strobe.
            key_valid <= (state_nxt == S_ACCEPT);
            case (state)
                S_SCAN: begin
                    if (state_nxt == S_DEB_P) begin
                        rows      <= row_d;
                        pend_code <= dec_code;
                    end else begin
                        rows <= {rows[2:0], rows[3]};
                    end
                end
                S_DEB_P: if (state_nxt == S_ACCEPT) key_code <= pend_code;
                S_ACCEPT: begin
                    if (key_code <= 4'd9 && !entry_full) begin
                        entry       <= (entry << 4) | PW'(key_code);
                        digit_cnt   <= digit_cnt + 4'd1;
                        crct_pwd    <= 1'b0;
                        incrct_pwd  <= 1'b0;
                        pwd_updated <= 1'b0;
                    end else if (key_code == 4'hA) begin
                        entry       <= '0;
                        digit_cnt   <= 4'd0;
                        crct_pwd    <= 1'b0;
                        incrct_pwd  <= 1'b0;
                        pwd_updated <= 1'b0;
                    end
                end
                S_CHECK: begin
                    digit_cnt <= 4'd0;
                    entry     <= '0;
                    if (prog_en) begin
                        password    <= entry;
                        pwd_updated <= 1'b1;
                    end else if (match) begin
                        crct_pwd <= 1'b1;
                        fail_cnt <= 4'd0;
                    end else begin
                        incrct_pwd <= 1'b1;
                        if (fail_inc == 4'(MAX_TRIES)) begin
                            fail_cnt <= 4'd0;
                            locked   <= 1'b1;
                            rows     <= 4'hF;
                        end else begin
                            fail_cnt <= fail_inc;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (state_nxt == S_SCAN) begin
                        locked <= 1'b0;
                        rows   <= 4'b1110;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
